if_stage: RTL and testbench

Instruction fetch stage of the rv32i core. It sits between the instruction memory and decode, and feeds the decode/ALU path.
- Owns the fetch PC and issues word-aligned requests to instruction memory.
- Buffers returned instructions, paired with their PCs, in a small FIFO toward decode.
- Handles branch/jump redirects by flushing the buffer and discarding stale in-flight responses.

---
 rtl/if_stage_if.sv | 29 ++
 rtl/if_stage.sv | 148 ++++++++++++++
 tb/tb_if_stage.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_stage_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, redirect
// input from execute, and the instruction stream toward decode.
interface if_stage_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  // master: the fetch stage itself
  modport master (
    output imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
           redirect_valid, redirect_pc, if_ready
  );

  // slave: memory, execute and decode seen from outside the stage
  modport slave (
    input  imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
           redirect_valid, redirect_pc, if_ready
  );
endinterface

// File: rtl/if_stage.sv
// rv32i instruction fetch stage: owns the fetch PC, issues credit-limited
// word requests, pairs returning words with their PCs in a small FIFO, and
// squashes stale responses after a redirect.
module if_stage #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH      = 2,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input logic         clk,
  input logic         rst,
  if_stage_if.master  bus
);
  localparam int unsigned OCNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned FPTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned QPTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic [31:0]       fetch_pc_q, fetch_pc_d;
  logic [OCNT_W-1:0] out_cnt_q, out_cnt_d;
  logic [OCNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [FCNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
  logic [FPTR_W-1:0] fifo_rd_q, fifo_rd_d, fifo_wr_q, fifo_wr_d;
  logic [QPTR_W-1:0] q_rd_q, q_rd_d, q_wr_q, q_wr_d;

  logic [31:0] fifo_instr_q [FIFO_DEPTH];
  logic [31:0] fifo_pc_q    [FIFO_DEPTH];
  logic [31:0] inflight_pc_q [MAX_OUTSTANDING];
  logic [FIFO_DEPTH-1:0]      fifo_we;
  logic [MAX_OUTSTANDING-1:0] q_we;

  logic req_valid, accept, resp, push, pop, redirect;
  logic unused_redirect_lsbs;

  assign redirect = bus.redirect_valid;
  assign resp     = bus.imem_resp_valid;

  // Credits count both in-flight requests and buffered words so every
  // response is guaranteed a FIFO slot.
  assign req_valid = !rst && !redirect
                  && (32'(out_cnt_q) < MAX_OUTSTANDING)
                  && ((32'(out_cnt_q) + 32'(fifo_cnt_q)) < FIFO_DEPTH);
  assign accept = req_valid && bus.imem_req_ready;
  // Responses belonging to the pre-redirect stream are never buffered.
  assign push   = resp && !redirect && (drop_cnt_q == '0);
  assign pop    = bus.if_valid && bus.if_ready;

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc_q;
  assign bus.if_valid       = !rst && (fifo_cnt_q != '0);
  assign bus.if_instr       = fifo_instr_q[fifo_rd_q];
  assign bus.if_pc          = fifo_pc_q[fifo_rd_q];

  assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];

  for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_fifo_we
    assign fifo_we[gi] = push && (fifo_wr_q == FPTR_W'(gi));
  end
  for (genvar gi = 0; gi < MAX_OUTSTANDING; gi++) begin : g_q_we
    assign q_we[gi] = accept && (q_wr_q == QPTR_W'(gi));
  end

  // Next-state for PC, credit counters and queue/FIFO pointers; redirect wins.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    out_cnt_d  = out_cnt_q;
    drop_cnt_d = drop_cnt_q;
    fifo_cnt_d = fifo_cnt_q;
    fifo_rd_d  = fifo_rd_q;
    fifo_wr_d  = fifo_wr_q;
    q_rd_d     = q_rd_q;
    q_wr_d     = q_wr_q;
    if (redirect) begin
      fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
      out_cnt_d  = out_cnt_q - OCNT_W'(resp);
      drop_cnt_d = out_cnt_q - OCNT_W'(resp);
      fifo_cnt_d = '0;
      fifo_rd_d  = '0;
      fifo_wr_d  = '0;
      q_rd_d     = '0;
      q_wr_d     = '0;
    end else begin
      if (accept) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        q_wr_d = (q_wr_q == QPTR_W'(MAX_OUTSTANDING - 1)) ? '0 : q_wr_q + 1'b1;
      end
      out_cnt_d = out_cnt_q + OCNT_W'(accept) - OCNT_W'(resp);
      if (resp && (drop_cnt_q != '0)) begin
        drop_cnt_d = drop_cnt_q - 1'b1;
      end
      if (push) begin
        fifo_wr_d = (fifo_wr_q == FPTR_W'(FIFO_DEPTH - 1)) ? '0 : fifo_wr_q + 1'b1;
        q_rd_d    = (q_rd_q == QPTR_W'(MAX_OUTSTANDING - 1)) ? '0 : q_rd_q + 1'b1;
      end
      if (pop) begin
        fifo_rd_d = (fifo_rd_q == FPTR_W'(FIFO_DEPTH - 1)) ? '0 : fifo_rd_q + 1'b1;
      end
      fifo_cnt_d = fifo_cnt_q + FCNT_W'(push) - FCNT_W'(pop);
    end
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
      fifo_cnt_q <= '0;
      fifo_rd_q  <= '0;
      fifo_wr_q  <= '0;
      q_rd_q     <= '0;
      q_wr_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      fifo_cnt_q <= fifo_cnt_d;
      fifo_rd_q  <= fifo_rd_d;
      fifo_wr_q  <= fifo_wr_d;
      q_rd_q     <= q_rd_d;
      q_wr_q     <= q_wr_d;
    end
  end

  // Instruction buffer and in-flight PC storage; cleared so the decode
  // outputs read zero until the first word lands.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (rst) begin
        fifo_instr_q[i] <= '0;
        fifo_pc_q[i]    <= '0;
      end else if (fifo_we[i]) begin
        fifo_instr_q[i] <= bus.imem_resp_data;
        fifo_pc_q[i]    <= inflight_pc_q[q_rd_q];
      end
    end
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      if (rst) begin
        inflight_pc_q[i] <= '0;
      end else if (q_we[i]) begin
        inflight_pc_q[i] <= fetch_pc_q;
      end
    end
  end

  // A response with nothing outstanding means the memory broke protocol.
  resp_has_request: assert property (@(posedge clk) disable iff (rst)
    resp |-> (out_cnt_q != '0));
endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: per-cycle vector table plus hand-written
// redirect, wrap and mid-stream reset sequences against a simple memory.
module tb_if_stage;
  logic clk;
  logic rst;
  if_stage_if bus ();

  if_stage dut (.clk(clk), .rst(rst), .bus(bus));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit          rst;
    bit          ready;
    bit          if_ready;
    bit          exp_rv;
    logic [31:0] exp_addr;
    bit          exp_iv;
    logic [31:0] exp_pc;
  } vec_t;

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } out_t;

  vec_t  vecs[$];
  mreq_t mq[$];
  out_t  got[$];
  int    cyc = 0;
  int    lat = 1;
  int    total = 0;
  int    bad = 0;

  task automatic add(input bit r, input bit rd, input bit ir, input bit rv,
                     input logic [31:0] a, input bit iv, input logic [31:0] pc);
    vec_t v;
    v.rst = r; v.ready = rd; v.if_ready = ir; v.exp_rv = rv;
    v.exp_addr = a; v.exp_iv = iv; v.exp_pc = pc;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Apply this cycle's inputs (memory answers in order after lat cycles).
  task automatic drive(input bit r, input bit rd, input bit ir, input bit redir,
                       input logic [31:0] rpc);
    rst = r;
    bus.imem_req_ready  = rd;
    bus.if_ready        = ir;
    bus.redirect_valid  = redir;
    bus.redirect_pc     = rpc;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = 32'h0;
    if (r) begin
      mq.delete();
    end else if (mq.size() > 0 && mq[0].due <= cyc) begin
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data  = mq[0].addr >> 2;
      void'(mq.pop_front());
    end
    #1;
  endtask

  // Record handshakes, then advance one clock.
  task automatic tick();
    mreq_t m;
    out_t  o;
    if (bus.imem_req_valid && bus.imem_req_ready) begin
      m.addr = bus.imem_req_addr;
      m.due  = cyc + lat;
      mq.push_back(m);
    end
    if (bus.if_valid && bus.if_ready) begin
      o.pc = bus.if_pc;
      o.instr = bus.if_instr;
      got.push_back(o);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic wait_got(input int n, input int budget, input string name);
    int k = 0;
    while (got.size() < n && k < budget) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      tick();
      k++;
    end
    total++;
    if (got.size() < n) begin
      bad++;
      $display("FAIL %s timeout delivered=%0d required=%0d", name, got.size(), n);
    end
  endtask

  task automatic chk_got(input int i, input logic [31:0] pc, input string name);
    if (got.size() > i) begin
      chk({name, " pc"}, got[i].pc, pc);
      chk({name, " instr"}, got[i].instr, pc >> 2);
    end else begin
      total++;
      bad++;
      $display("FAIL %s missing entry %0d required pc=%h", name, i, pc);
    end
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    got.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    // Steady stream, 1-cycle memory, decode always ready.
    add(1,1,1, 0,32'h0,  0,32'h0);
    add(0,1,1, 1,32'h0,  0,32'h0);
    add(0,1,1, 1,32'h4,  0,32'h0);
    add(0,1,1, 0,32'h0,  1,32'h0);
    add(0,1,1, 1,32'h8,  1,32'h4);
    add(0,1,1, 1,32'hC,  0,32'h0);
    add(0,1,1, 0,32'h0,  1,32'h8);
    add(0,1,1, 1,32'h10, 1,32'hC);
    add(0,1,1, 1,32'h14, 0,32'h0);
    add(0,1,1, 0,32'h0,  1,32'h10);
    // Decode stalled 10 cycles: only two requests, head stays at 0x0.
    add(1,1,0, 0,32'h0,  0,32'h0);
    add(0,1,0, 1,32'h0,  0,32'h0);
    add(0,1,0, 1,32'h4,  0,32'h0);
    for (int i = 0; i < 8; i++) add(0,1,0, 0,32'h0, 1,32'h0);
    add(0,1,1, 0,32'h0,  1,32'h0);
    add(0,1,1, 1,32'h8,  1,32'h4);
    add(0,1,1, 1,32'hC,  0,32'h0);
    add(0,1,1, 0,32'h0,  1,32'h8);
    add(0,1,1, 1,32'h10, 1,32'hC);
    // Memory not ready: request held with a stable address.
    add(1,1,1, 0,32'h0,  0,32'h0);
    for (int i = 0; i < 5; i++) add(0,0,1, 1,32'h0, 0,32'h0);
    add(0,1,1, 1,32'h0,  0,32'h0);
    add(0,1,1, 1,32'h4,  0,32'h0);
    add(0,1,1, 0,32'h0,  1,32'h0);

    rst = 1'b1;
    bus.imem_req_ready = 1'b0; bus.if_ready = 1'b0;
    bus.redirect_valid = 1'b0; bus.redirect_pc = 32'h0;
    bus.imem_resp_valid = 1'b0; bus.imem_resp_data = 32'h0;
    @(negedge clk);

    // Reset state.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("rst req_valid", bus.imem_req_valid, 1'b0);
    chk("rst if_valid", bus.if_valid, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("post-rst if_valid", bus.if_valid, 1'b0);
    chk("post-rst if_pc", bus.if_pc, 32'h0);
    chk("post-rst if_instr", bus.if_instr, 32'h0);
    chk("post-rst req_valid", bus.imem_req_valid, 1'b1);
    chk("post-rst addr", bus.imem_req_addr, 32'h0);
    tick();

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].ready, vecs[i].if_ready, 1'b0, 32'h0);
      chk($sformatf("vec%0d req_valid", i), bus.imem_req_valid, vecs[i].exp_rv);
      if (vecs[i].exp_rv) chk($sformatf("vec%0d addr", i), bus.imem_req_addr, vecs[i].exp_addr);
      chk($sformatf("vec%0d if_valid", i), bus.if_valid, vecs[i].exp_iv);
      if (vecs[i].exp_iv) begin
        chk($sformatf("vec%0d if_pc", i), bus.if_pc, vecs[i].exp_pc);
        chk($sformatf("vec%0d if_instr", i), bus.if_instr, vecs[i].exp_pc >> 2);
      end
      tick();
    end

    // Redirect to 0x100 with 0x8 and 0xC in flight (3-cycle memory).
    lat = 3;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      tick();
    end
    chk_got(0, 32'h0, "t3 pre0");
    chk_got(1, 32'h4, "t3 pre1");
    drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h100);
    chk("t3 inflight", mq.size(), 2);
    chk("t3 redirect req_valid", bus.imem_req_valid, 1'b0);
    tick();
    got.delete();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("t3 flushed if_valid", bus.if_valid, 1'b0);
    chk("t3 new addr", bus.imem_req_addr, 32'h100);
    tick();
    wait_got(2, 40, "t3 deliver");
    chk_got(0, 32'h100, "t3 first");
    chk_got(1, 32'h104, "t3 second");

    // Redirect to 0x102 coincident with a response.
    lat = 1;
    do_reset();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h102);
    chk("t5 resp present", bus.imem_resp_valid, 1'b1);
    chk("t5 redirect req_valid", bus.imem_req_valid, 1'b0);
    tick();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("t5 dropped if_valid", bus.if_valid, 1'b0);
    chk("t5 req_valid", bus.imem_req_valid, 1'b1);
    chk("t5 aligned addr", bus.imem_req_addr, 32'h100);
    tick();
    wait_got(1, 20, "t5 deliver");
    chk_got(0, 32'h100, "t5 first");

    // Fetch PC wraps from 0xFFFF_FFFC to 0x0.
    do_reset();
    drive(1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
    tick();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("wrap first addr", bus.imem_req_addr, 32'hFFFF_FFFC);
    tick();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("wrap req_valid", bus.imem_req_valid, 1'b1);
    chk("wrap next addr", bus.imem_req_addr, 32'h0);
    tick();
    wait_got(2, 20, "wrap deliver");
    chk_got(0, 32'hFFFF_FFFC, "wrap d0");
    chk_got(1, 32'h0, "wrap d1");

    // One-cycle reset with the FIFO full.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      tick();
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("t6 full if_valid", bus.if_valid, 1'b1);
    chk("t6 full req_valid", bus.imem_req_valid, 1'b0);
    tick();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("t6 in-rst if_valid", bus.if_valid, 1'b0);
    chk("t6 in-rst req_valid", bus.imem_req_valid, 1'b0);
    tick();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("t6 after if_valid", bus.if_valid, 1'b0);
    chk("t6 after req_valid", bus.imem_req_valid, 1'b1);
    chk("t6 after addr", bus.imem_req_addr, 32'h0);
    tick();
    wait_got(2, 20, "t6 deliver");
    chk_got(0, 32'h0, "t6 d0");
    chk_got(1, 32'h4, "t6 d1");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
